mod_reduce_seq: RTL and testbench

Sequential bit-serial modular reducer: takes the 520-bit product from the 264x256 multiplier and a 256-bit modulus, and returns the product mod modulus. It sits directly downstream of the multiplier in the field-arithmetic datapath and uses the same start/valid handshake. It retires one product bit per cycle using restoring shift-subtract.

---
 rtl/mod_reduce_seq.sv | 125 ++++++++++++
 tb/tb_mod_reduce_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mod_reduce_seq.sv
// Bit-serial restoring reducer: remainder = product mod modulus, one product bit per cycle.
// state  | meaning
// IDLE   | waiting for start
// REDUCE | 520 shift-subtract iterations, MSB first
// DONE   | result held with valid high until start drops
module mod_reduce_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [519:0] product,
    input  logic [255:0] modulus,
    output logic         valid,
    output logic         busy,
    output logic [255:0] remainder,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [519:0]  r_prod;
    logic [255:0]  r_m;
    logic [255:0]  r_rem;
    logic [9:0]    r_cnt;
    logic          r_valid;
    logic          r_err;
    logic [255:0]  r_remainder;

    logic [256:0]  w_t;
    logic          w_ge;
    logic [255:0]  w_diff;
    logic [255:0]  w_r_next;

    // r < m < 2^256 holds throughout, so t - m always fits in the low 256 bits
    assign w_t      = {r_rem, r_prod[519]};
    assign w_ge     = (w_t >= {1'b0, r_m});
    assign w_diff   = w_t[255:0] - r_m;
    assign w_r_next = w_ge ? w_diff : w_t[255:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (modulus == 256'd0) ? S_DONE : S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (r_cnt == 10'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_valid && !start) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod      <= '0;
            r_m         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_prod <= product;
                        r_m    <= modulus;
                        r_rem  <= '0;
                        r_cnt  <= 10'd519;
                        r_err  <= 1'b0;
                    end
                end
                S_REDUCE: begin
                    r_rem  <= w_r_next;
                    r_prod <= {r_prod[518:0], 1'b0};
                    if (r_cnt == 10'd0) begin
                        r_remainder <= w_r_next;
                        r_valid     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 10'd1;
                    end
                end
                S_DONE: begin
                    // Entering DONE without valid only happens on a zero modulus
                    if (!r_valid) begin
                        r_valid     <= 1'b1;
                        r_err       <= 1'b1;
                        r_remainder <= '0;
                    end else if (!start) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid     = r_valid;
    assign busy      = (r_state == S_REDUCE);
    assign remainder = r_remainder;
    assign err       = r_err;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed bench for mod_reduce_seq: table of reductions plus zero-modulus and reset corner cases.
module tb_mod_reduce_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [519:0] product = '0;
    logic [255:0] modulus = '0;
    logic         valid;
    logic         busy;
    logic [255:0] remainder;
    logic         err;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [519:0] p;
        logic [255:0] m;
        logic [255:0] rem;
    } vec_t;

    vec_t vecs [6];

    mod_reduce_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .product   (product),
        .modulus   (modulus),
        .valid     (valid),
        .busy      (busy),
        .remainder (remainder),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present a request, let the accepting edge pass, then scramble the inputs
    task automatic accept(input logic [519:0] p, input logic [255:0] m);
        @(negedge clk);
        product = p;
        modulus = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        product = ~p;
        modulus = ~m;
    endtask

    task automatic finish_op(input string tag, input logic [255:0] exp_rem, input bit toggle);
        int n;
        int bc;
        @(negedge clk);
        start = 1'b0;
        bc = busy ? 1 : 0;
        n = 0;
        while (!valid && n < 600) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!valid) begin
                if (busy) bc++;
                if (toggle) start = n[0];
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 256'(n), 256'd520);
        chk({tag, " busy_cycles"}, 256'(bc), 256'd520);
        chk({tag, " remainder"}, remainder, exp_rem);
        chk({tag, " err"}, 256'(err), 256'd0);
        chk({tag, " busy_after"}, 256'(busy), 256'd0);
        @(negedge clk);
        chk({tag, " valid_cleared"}, 256'(valid), 256'd0);
    endtask

    initial begin
        logic [255:0] m_big;
        m_big = (256'd1 << 255) + 256'd1;
        vecs[0] = '{p: 520'd100,        m: 256'd7,          rem: 256'd2};
        vecs[1] = '{p: 520'd1 << 519,   m: {256{1'b1}},     rem: 256'd128};
        vecs[2] = '{p: 520'd5,          m: 256'd9,          rem: 256'd5};
        vecs[3] = '{p: 520'(m_big) * 520'd3, m: m_big,      rem: 256'd0};
        vecs[4] = '{p: {520{1'b1}},     m: 256'd2,          rem: 256'd1};
        vecs[5] = '{p: 520'd123456789,  m: 256'd1000,       rem: 256'd789};

        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset valid", 256'(valid), 256'd0);
        chk("reset busy", 256'(busy), 256'd0);
        chk("reset err", 256'(err), 256'd0);
        chk("reset remainder", remainder, 256'd0);

        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].p, vecs[i].m);
            finish_op($sformatf("vec%0d", i), vecs[i].rem, 1'b0);
        end

        // Reset in the middle of a reduction
        accept(520'd100, 256'd7);
        start = 1'b0;
        repeat (200) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset valid", 256'(valid), 256'd0);
        chk("midreset busy", 256'(busy), 256'd0);
        chk("midreset err", 256'(err), 256'd0);
        chk("midreset remainder", remainder, 256'd0);
        #4 rst_n = 1'b1;
        accept(520'd100, 256'd7);
        finish_op("after_reset", 256'd2, 1'b1);

        // Zero modulus with start held through DONE
        accept(520'd12345, 256'd0);
        @(negedge clk);
        chk("zero busy_at_accept", 256'(busy), 256'd0);
        @(posedge clk);
        @(negedge clk);
        chk("zero valid", 256'(valid), 256'd1);
        chk("zero err", 256'(err), 256'd1);
        chk("zero remainder", remainder, 256'd0);
        chk("zero busy", 256'(busy), 256'd0);
        repeat (3) @(negedge clk);
        chk("zero hold valid", 256'(valid), 256'd1);
        chk("zero hold busy", 256'(busy), 256'd0);
        start = 1'b0;
        @(negedge clk);
        chk("zero release valid", 256'(valid), 256'd0);

        accept(520'd5, 256'd9);
        finish_op("post_zero", 256'd5, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
